// File: rtl/writeback_stage_if.sv
// MEM/WB stage bundle: MEM-stage results and hazard controls in, register-file write port and debug counter out.
interface writeback_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  stall;
    logic                  flush;
    logic                  in_valid;
    logic                  in_regwrite;
    logic                  in_memtoreg;
    logic [1:0]            in_regdst;
    logic [1:0]            in_memsize;
    logic                  in_memunsigned;
    logic [1:0]            in_byteoffset;
    logic [DATA_W-1:0]     in_aluresult;
    logic [DATA_W-1:0]     in_readdata;
    logic [DATA_W-1:0]     in_pcplus4;
    logic [REG_ADDR_W-1:0] in_rt;
    logic [REG_ADDR_W-1:0] in_rd;

    logic                  write_enable;
    logic [REG_ADDR_W-1:0] write_register;
    logic [DATA_W-1:0]     write_data;
    logic                  wb_valid;
    logic [31:0]           retire_count;

    modport master (
        output stall, flush, in_valid, in_regwrite, in_memtoreg, in_regdst, in_memsize,
               in_memunsigned, in_byteoffset, in_aluresult, in_readdata, in_pcplus4, in_rt, in_rd,
        input  write_enable, write_register, write_data, wb_valid, retire_count
    );

    modport slave (
        input  stall, flush, in_valid, in_regwrite, in_memtoreg, in_regdst, in_memsize,
               in_memunsigned, in_byteoffset, in_aluresult, in_readdata, in_pcplus4, in_rt, in_rd,
        output write_enable, write_register, write_data, wb_valid, retire_count
    );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB register plus writeback mux: 1-cycle latency, outputs purely from the stage register.
// Stall holds the stage, flush inserts a bubble (flush wins); no backpressure is generated here.
module writeback_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int LINK_REG   = 31
) (
    input  logic             clk,
    input  logic             rst,
    writeback_stage_if.slave wb
);

    typedef struct packed {
        logic                  regwrite;
        logic                  memtoreg;
        logic [1:0]            regdst;
        logic [1:0]            memsize;
        logic                  memunsigned;
        logic [1:0]            byteoffset;
        logic [DATA_W-1:0]     aluresult;
        logic [DATA_W-1:0]     readdata;
        logic [DATA_W-1:0]     pcplus4;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
    } stage_t;

    stage_t      stage_q;
    logic        valid_q;
    logic [31:0] retire_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q    <= '0;
            valid_q    <= 1'b0;
            retire_cnt <= '0;
        end else if (wb.flush) begin
            valid_q <= 1'b0;
        end else if (!wb.stall) begin
            valid_q              <= wb.in_valid;
            stage_q.regwrite     <= wb.in_regwrite;
            stage_q.memtoreg     <= wb.in_memtoreg;
            stage_q.regdst       <= wb.in_regdst;
            stage_q.memsize      <= wb.in_memsize;
            stage_q.memunsigned  <= wb.in_memunsigned;
            stage_q.byteoffset   <= wb.in_byteoffset;
            stage_q.aluresult    <= wb.in_aluresult;
            stage_q.readdata     <= wb.in_readdata;
            stage_q.pcplus4      <= wb.in_pcplus4;
            stage_q.rt           <= wb.in_rt;
            stage_q.rd           <= wb.in_rd;
            if (wb.in_valid) begin
                retire_cnt <= retire_cnt + 32'd1;
            end
        end
    end

    logic [REG_ADDR_W-1:0] dest_reg;
    logic [31:0]           mem_word;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_W-1:0]     load_data;
    logic [DATA_W-1:0]     sel_data;

    always_comb begin
        dest_reg = stage_q.rt;
        case (stage_q.regdst)
            2'b01:   dest_reg = stage_q.rd;
            2'b10:   dest_reg = REG_ADDR_W'(LINK_REG);
            default: dest_reg = stage_q.rt;
        endcase
    end

    // Memory word is big-endian: lowest offset lives in the most significant byte.
    always_comb begin
        mem_word = stage_q.readdata[31:0];
        ld_byte  = 8'h00;
        case (stage_q.byteoffset)
            2'd0:    ld_byte = mem_word[31:24];
            2'd1:    ld_byte = mem_word[23:16];
            2'd2:    ld_byte = mem_word[15:8];
            default: ld_byte = mem_word[7:0];
        endcase
        ld_half = stage_q.byteoffset[1] ? mem_word[15:0] : mem_word[31:16];

        load_data = stage_q.readdata;
        case (stage_q.memsize)
            2'b00:   load_data = {{(DATA_W-8){ld_byte[7] & ~stage_q.memunsigned}}, ld_byte};
            2'b01:   load_data = {{(DATA_W-16){ld_half[15] & ~stage_q.memunsigned}}, ld_half};
            default: load_data = stage_q.readdata;
        endcase
    end

    always_comb begin
        sel_data = stage_q.aluresult;
        if (stage_q.regdst == 2'b10) begin
            sel_data = stage_q.pcplus4 + DATA_W'(4);
        end else if (stage_q.memtoreg) begin
            sel_data = load_data;
        end
    end

    assign wb.write_register = dest_reg;
    assign wb.write_enable   = valid_q & stage_q.regwrite & (dest_reg != '0);
    assign wb.write_data     = valid_q ? sel_data : '0;
    assign wb.wb_valid       = valid_q;
    assign wb.retire_count   = retire_cnt;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized and directed bench for writeback_stage against an instruction-level reference model.
module tb_writeback_stage;

    logic clk;
    logic rst;

    writeback_stage_if wbif ();

    writeback_stage dut (
        .clk (clk),
        .rst (rst),
        .wb  (wbif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    // Reference model: the instruction currently held in writeback.
    logic        m_valid;
    logic        m_regwrite, m_memtoreg, m_uns;
    logic [1:0]  m_regdst, m_size, m_off;
    logic [31:0] m_alu, m_rdata, m_pc4;
    logic [4:0]  m_rt, m_rd;
    logic [31:0] m_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_regwrite = 0; m_memtoreg = 0; m_uns = 0;
        m_regdst = 0; m_size = 0; m_off = 0;
        m_alu = 0; m_rdata = 0; m_pc4 = 0; m_rt = 0; m_rd = 0;
        m_count = 0;
    endtask

    task automatic model_edge();
        if (rst) return;
        if (wbif.flush) begin
            m_valid = 0;
        end else if (!wbif.stall) begin
            m_valid    = wbif.in_valid;
            m_regwrite = wbif.in_regwrite;
            m_memtoreg = wbif.in_memtoreg;
            m_regdst   = wbif.in_regdst;
            m_size     = wbif.in_memsize;
            m_uns      = wbif.in_memunsigned;
            m_off      = wbif.in_byteoffset;
            m_alu      = wbif.in_aluresult;
            m_rdata    = wbif.in_readdata;
            m_pc4      = wbif.in_pcplus4;
            m_rt       = wbif.in_rt;
            m_rd       = wbif.in_rd;
            if (wbif.in_valid) m_count = m_count + 1;
        end
    endtask

    function automatic logic [4:0] exp_wr();
        if (m_regdst == 2'd1) return m_rd;
        if (m_regdst == 2'd2) return 5'd31;
        return m_rt;
    endfunction

    function automatic logic [31:0] exp_load();
        logic [31:0] v;
        if (m_size >= 2) return m_rdata;
        if (m_size == 0) begin
            v = (m_rdata >> (8 * (3 - int'(m_off)))) & 32'hFF;
            if (!m_uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else begin
            v = (m_rdata >> (m_off[1] ? 0 : 16)) & 32'hFFFF;
            if (!m_uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_wd();
        if (!m_valid) return 32'h0;
        if (m_regdst == 2'd2) return m_pc4 + 32'd4;
        if (m_memtoreg) return exp_load();
        return m_alu;
    endfunction

    function automatic logic exp_we();
        return m_valid && m_regwrite && (exp_wr() != 5'd0);
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_valid"}, 32'(wbif.wb_valid), 32'(m_valid));
        chk({tag, "_we"}, 32'(wbif.write_enable), 32'(exp_we()));
        chk({tag, "_wd"}, wbif.write_data, exp_wd());
        chk({tag, "_cnt"}, wbif.retire_count, m_count);
        if (m_valid) chk({tag, "_wr"}, 32'(wbif.write_register), 32'(exp_wr()));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic set_instr(input logic v, input logic rw, input logic m2r, input logic [1:0] dst,
                             input logic [1:0] sz, input logic uns, input logic [1:0] off,
                             input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] pc4,
                             input logic [4:0] rt, input logic [4:0] rd);
        wbif.in_valid = v; wbif.in_regwrite = rw; wbif.in_memtoreg = m2r; wbif.in_regdst = dst;
        wbif.in_memsize = sz; wbif.in_memunsigned = uns; wbif.in_byteoffset = off;
        wbif.in_aluresult = alu; wbif.in_readdata = rdata; wbif.in_pcplus4 = pc4;
        wbif.in_rt = rt; wbif.in_rd = rd;
    endtask

    task automatic set_random();
        set_instr(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
                  2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    endtask

    logic [31:0] snap_wd, snap_cnt;
    logic [4:0]  snap_wr;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        wbif.stall = 1'b0;
        wbif.flush = 1'b0;
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();

        #1 rst = 1'b1;
        #1;
        chk("rst_we", 32'(wbif.write_enable), 32'h0);
        chk("rst_wr", 32'(wbif.write_register), 32'h0);
        chk("rst_wd", wbif.write_data, 32'h0);
        chk("rst_valid", 32'(wbif.wb_valid), 32'h0);
        chk("rst_cnt", wbif.retire_count, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // ALU result to rd
        set_instr(1, 1, 0, 2'b01, 2'b10, 0, 0, 32'h0000_1234, 32'h0, 32'h0, 5'd0, 5'd5);
        tick("alu");
        chk("alu_we", 32'(wbif.write_enable), 32'h1);
        chk("alu_wr", 32'(wbif.write_register), 32'd5);
        chk("alu_wd", wbif.write_data, 32'h0000_1234);
        chk("alu_cnt", wbif.retire_count, 32'd1);

        // Byte loads, signed and unsigned
        set_instr(1, 1, 1, 2'b00, 2'b00, 0, 2'd1, 32'h0, 32'h12F4_5678, 32'h0, 5'd3, 5'd0);
        tick("lb");
        chk("lb_wd", wbif.write_data, 32'hFFFF_FFF4);
        wbif.in_memunsigned = 1'b1;
        tick("lbu");
        chk("lbu_wd", wbif.write_data, 32'h0000_00F4);

        // Halfword and word loads
        set_instr(1, 1, 1, 2'b00, 2'b01, 0, 2'd2, 32'h0, 32'hAAAA_8001, 32'h0, 5'd4, 5'd0);
        tick("lh");
        chk("lh_wd", wbif.write_data, 32'hFFFF_8001);
        set_instr(1, 1, 1, 2'b00, 2'b10, 0, 2'd3, 32'h0, 32'hAAAA_8001, 32'h0, 5'd4, 5'd0);
        tick("lw");
        chk("lw_wd", wbif.write_data, 32'hAAAA_8001);

        // Link write and $0 suppression
        set_instr(1, 1, 0, 2'b10, 2'b10, 0, 0, 32'h5555_5555, 32'h0, 32'h0040_0010, 5'd2, 5'd3);
        tick("jal");
        chk("jal_wr", 32'(wbif.write_register), 32'd31);
        chk("jal_wd", wbif.write_data, 32'h0040_0014);
        set_instr(1, 1, 0, 2'b00, 2'b10, 0, 0, 32'h7777_0000, 32'h0, 32'h0, 5'd0, 5'd9);
        tick("r0");
        chk("r0_we", 32'(wbif.write_enable), 32'h0);

        // Stall freezes the stage, then stall+flush bubbles it
        set_instr(1, 1, 0, 2'b01, 2'b10, 0, 0, 32'h0000_ABCD, 32'h0, 32'h0, 5'd0, 5'd9);
        tick("pre_stall");
        snap_wd = wbif.write_data;
        snap_wr = wbif.write_register;
        snap_cnt = wbif.retire_count;
        wbif.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_random();
            wbif.in_valid = 1'b1;
            tick("stall");
            chk("stall_we", 32'(wbif.write_enable), 32'h1);
            chk("stall_wd", wbif.write_data, snap_wd);
            chk("stall_wr", 32'(wbif.write_register), 32'(snap_wr));
            chk("stall_cnt", wbif.retire_count, snap_cnt);
        end
        wbif.flush = 1'b1;
        tick("flush");
        chk("flush_valid", 32'(wbif.wb_valid), 32'h0);
        chk("flush_we", 32'(wbif.write_enable), 32'h0);
        chk("flush_wd", wbif.write_data, 32'h0);
        chk("flush_cnt", wbif.retire_count, snap_cnt);
        wbif.stall = 1'b0;
        wbif.flush = 1'b0;

        // Asynchronous reset with a write pending
        set_instr(1, 1, 0, 2'b01, 2'b10, 0, 0, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd0, 5'd7);
        tick("pre_rst");
        chk("pre_rst_we", 32'(wbif.write_enable), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst_we", 32'(wbif.write_enable), 32'h0);
        chk("arst_wr", 32'(wbif.write_register), 32'h0);
        chk("arst_wd", wbif.write_data, 32'h0);
        chk("arst_cnt", wbif.retire_count, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_all("in_rst");
        rst = 1'b0;

        // Counter wraparound
        force dut.retire_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.retire_cnt;
        m_count = 32'hFFFF_FFFE;
        set_instr(1, 1, 0, 2'b01, 2'b10, 0, 0, 32'h1, 32'h0, 32'h0, 5'd0, 5'd1);
        tick("wrap1");
        chk("wrap1_cnt", wbif.retire_count, 32'hFFFF_FFFF);
        tick("wrap2");
        chk("wrap2_cnt", wbif.retire_count, 32'h0);

        // Random traffic with stalls and flushes
        for (int i = 0; i < 400; i++) begin
            set_random();
            wbif.stall = ($urandom_range(0, 4) == 0);
            wbif.flush = ($urandom_range(0, 7) == 0);
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
